// File: rtl/tank_pkg.sv
// Shared types and constants for the player tank controller: facing enum,
// keyboard scan codes, screen defaults and saturating 10-bit helpers.
package tank_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h58;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : 10'd0;
  endfunction

  // Sum is formed at 11 bits so the limit compare never sees a wrapped value.
  function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [9:0] b,
                                         input logic [9:0] lim);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[9:0];
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One projectile: latches position and heading on spawn, advances once per
// tick and retires itself when the next step would leave the visible area.
module bullet_slot
  import tank_pkg::*;
#(
  parameter int BULLET_SIZE = 8,
  parameter int BULLET_STEP = 4,
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [2:0] spawn_dir,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       active,
  output logic       hit
);

  localparam logic [10:0] SIZE  = 11'(BULLET_SIZE);
  localparam logic [10:0] STEP  = 11'(BULLET_STEP);
  localparam logic [10:0] LIM_X = 11'(SCREEN_W);
  localparam logic [10:0] LIM_Y = 11'(SCREEN_H);
  localparam logic [9:0]  MOVE  = 10'(BULLET_STEP);

  logic       active_q, active_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [2:0] dir_q, dir_d;
  logic [10:0] x_w, y_w;

  assign x_w = {1'b0, x_q};
  assign y_w = {1'b0, y_q};

  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    if (tick) begin
      if (spawn) begin
        active_d = 1'b1;
        x_d      = spawn_x;
        y_d      = spawn_y;
        dir_d    = spawn_dir;
      end else if (active_q) begin
        // Exit is decided on the pre-move position; the slot stays put when retired.
        case (dir_q)
          DIR_UP:    if (y_w < STEP) active_d = 1'b0; else y_d = y_q - MOVE;
          DIR_DOWN:  if (y_w + SIZE + STEP > LIM_Y) active_d = 1'b0; else y_d = y_q + MOVE;
          DIR_LEFT:  if (x_w < STEP) active_d = 1'b0; else x_d = x_q - MOVE;
          DIR_RIGHT: if (x_w + SIZE + STEP > LIM_X) active_d = 1'b0; else x_d = x_q + MOVE;
          default:   active_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      dir_q    <= DIR_UP;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
    end
  end

  assign active = active_q;
  assign hit    = active_q
                  && (draw_x >= x_q) && ({1'b0, draw_x} < x_w + SIZE)
                  && (draw_y >= y_q) && ({1'b0, draw_y} < y_w + SIZE);

endmodule

// File: rtl/tank_ctrl.sv
// Player tank: keycode-driven motion and facing, edge-triggered firing with
// cooldown, and a pool of bullet slots filled lowest-index-first.
module tank_ctrl
  import tank_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int TANK_SIZE   = 32,
  parameter int BULLET_SIZE = 8,
  parameter int TANK_STEP   = 1,
  parameter int BULLET_STEP = 4,
  parameter int COOLDOWN    = 15,
  parameter int X_START     = 500,
  parameter int Y_START     = 240,
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [7:0]             keycode,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic [9:0]             tank_X,
  output logic [9:0]             tank_Y,
  output logic [2:0]             tank_dir,
  output logic                   is_tank,
  output logic                   is_bullet,
  output logic [NUM_BULLETS-1:0] bullets_active,
  output logic                   fire
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [9:0]  TSTEP  = 10'(TANK_STEP);
  localparam logic [9:0]  TSIZE  = 10'(TANK_SIZE);
  localparam logic [9:0]  BSIZE  = 10'(BULLET_SIZE);
  localparam logic [9:0]  MUZZLE = 10'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [9:0]  X_MAX  = 10'(SCREEN_W - TANK_SIZE);
  localparam logic [9:0]  Y_MAX  = 10'(SCREEN_H - TANK_SIZE);
  localparam logic [10:0] TSIZE_W = 11'(TANK_SIZE);

  logic            frame_sync_q, frame_sync_d;
  logic            frame_dly_q, frame_dly_d;
  logic            tick_q, tick_d;
  logic [9:0]      tank_x_q, tank_x_d;
  logic [9:0]      tank_y_q, tank_y_d;
  dir_t            dir_q, dir_d;
  logic [CD_W-1:0] cooldown_q, cooldown_d;
  logic            enter_prev_q, enter_prev_d;
  logic            fire_q, fire_d;

  logic                   is_enter, fire_req, grant, found;
  logic [NUM_BULLETS-1:0] active, hit, alloc_oh, spawn_vec;
  logic [9:0]             spawn_x, spawn_y;

  // frame_clk is asynchronous to Clk: one sync stage, then a delay stage for the edge.
  always_comb begin
    frame_sync_d = frame_clk;
    frame_dly_d  = frame_sync_q;
    tick_d       = frame_sync_q & ~frame_dly_q;
  end

  always_comb begin
    tank_x_d = tank_x_q;
    tank_y_d = tank_y_q;
    dir_d    = dir_q;
    if (tick_q) begin
      case (keycode)
        KEY_W: begin dir_d = DIR_UP;    tank_y_d = sat_sub(tank_y_q, TSTEP);        end
        KEY_S: begin dir_d = DIR_DOWN;  tank_y_d = sat_add(tank_y_q, TSTEP, Y_MAX); end
        KEY_A: begin dir_d = DIR_LEFT;  tank_x_d = sat_sub(tank_x_q, TSTEP);        end
        KEY_D: begin dir_d = DIR_RIGHT; tank_x_d = sat_add(tank_x_q, TSTEP, X_MAX); end
        default: ;
      endcase
    end
  end

  // Allocation looks only at registered masks, so a slot retiring this tick stays busy.
  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    is_enter     = (keycode == KEY_ENTER);
    fire_req     = tick_q && is_enter && !enter_prev_q;
    grant        = fire_req && (cooldown_q == '0) && found;
    spawn_vec    = grant ? alloc_oh : '0;
    fire_d       = grant;
    enter_prev_d = tick_q ? is_enter : enter_prev_q;
    cooldown_d   = cooldown_q;
    if (grant)
      cooldown_d = CD_LOAD;
    else if (tick_q && (cooldown_q != '0))
      cooldown_d = cooldown_q - CD_W'(1);
  end

  always_comb begin
    spawn_x = tank_x_q + MUZZLE;
    spawn_y = sat_sub(tank_y_q, BSIZE);
    case (dir_q)
      DIR_DOWN:  begin spawn_x = tank_x_q + MUZZLE;         spawn_y = tank_y_q + TSIZE;  end
      DIR_LEFT:  begin spawn_x = sat_sub(tank_x_q, BSIZE);  spawn_y = tank_y_q + MUZZLE; end
      DIR_RIGHT: begin spawn_x = tank_x_q + TSIZE;          spawn_y = tank_y_q + MUZZLE; end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_sync_q <= 1'b0;
      frame_dly_q  <= 1'b0;
      tick_q       <= 1'b0;
      tank_x_q     <= 10'(X_START);
      tank_y_q     <= 10'(Y_START);
      dir_q        <= DIR_UP;
      cooldown_q   <= '0;
      enter_prev_q <= 1'b0;
      fire_q       <= 1'b0;
    end else begin
      frame_sync_q <= frame_sync_d;
      frame_dly_q  <= frame_dly_d;
      tick_q       <= tick_d;
      tank_x_q     <= tank_x_d;
      tank_y_q     <= tank_y_d;
      dir_q        <= dir_d;
      cooldown_q   <= cooldown_d;
      enter_prev_q <= enter_prev_d;
      fire_q       <= fire_d;
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .BULLET_SIZE(BULLET_SIZE),
      .BULLET_STEP(BULLET_STEP),
      .SCREEN_W   (SCREEN_W),
      .SCREEN_H   (SCREEN_H)
    ) u_slot (
      .clk      (Clk),
      .rst      (Reset),
      .tick     (tick_q),
      .spawn    (spawn_vec[g]),
      .spawn_x  (spawn_x),
      .spawn_y  (spawn_y),
      .spawn_dir(dir_q),
      .draw_x   (DrawX),
      .draw_y   (DrawY),
      .active   (active[g]),
      .hit      (hit[g])
    );
  end

  assign tank_X         = tank_x_q;
  assign tank_Y         = tank_y_q;
  assign tank_dir       = dir_q;
  assign bullets_active = active;
  assign fire           = fire_q;
  assign is_bullet      = |hit;
  assign is_tank        = (DrawX >= tank_x_q) && ({1'b0, DrawX} < {1'b0, tank_x_q} + TSIZE_W)
                       && (DrawY >= tank_y_q) && ({1'b0, DrawY} < {1'b0, tank_y_q} + TSIZE_W);

endmodule

// File: tb/tb_tank_ctrl.sv
// Directed bench for tank_ctrl: each frame pushes its expected post-tick
// snapshot; a monitor pops and compares when the tick's results appear.
module tb_tank_ctrl;

  localparam int W = 31;
  localparam logic [7:0] K_W    = 8'h1A;
  localparam logic [7:0] K_S    = 8'h16;
  localparam logic [7:0] K_A    = 8'h04;
  localparam logic [7:0] K_D    = 8'h07;
  localparam logic [7:0] K_EN   = 8'h58;
  localparam logic [7:0] K_NONE = 8'h00;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] DrawX, DrawY;
  logic [9:0] tank_X, tank_Y;
  logic [2:0] tank_dir;
  logic       is_tank, is_bullet, fire;
  logic [3:0] bullets_active;

  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int exp_fires   = 0;
  int fire_seen   = 0;

  tank_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .DrawX(DrawX), .DrawY(DrawY), .tank_X(tank_X), .tank_Y(tank_Y),
    .tank_dir(tank_dir), .is_tank(is_tank), .is_bullet(is_bullet),
    .bullets_active(bullets_active), .fire(fire)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: one frame_clk pulse with a held keycode and pixel
  task automatic frame(input logic [7:0] key, input logic [9:0] ex, input logic [9:0] ey,
                       input logic [2:0] ed, input logic [3:0] em, input logic ef,
                       input logic pc, input logic [9:0] dx, input logic [9:0] dy,
                       input logic et, input logic eb);
    exp_q.push_back({pc, ex, ey, ed, em, ef, et, eb});
    if (ef) exp_fires++;
    keycode   = key;
    DrawX     = dx;
    DrawY     = dy;
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic step(input logic [7:0] key, input logic [9:0] ex, input logic [9:0] ey,
                      input logic [2:0] ed, input logic [3:0] em, input logic ef);
    frame(key, ex, ey, ed, em, ef, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
  endtask

  // monitor: results of a tick are visible 3 Clk after the frame_clk edge
  initial begin
    logic [W-1:0] r;
    forever begin
      @(posedge frame_clk);
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        chk("tank_X", 32'(tank_X), 32'(r[29:20]));
        chk("tank_Y", 32'(tank_Y), 32'(r[19:10]));
        chk("tank_dir", 32'(tank_dir), 32'(r[9:7]));
        chk("bullets_active", 32'(bullets_active), 32'(r[6:3]));
        chk("fire", 32'(fire), 32'(r[2]));
        if (r[30]) begin
          chk("is_tank", 32'(is_tank), 32'(r[1]));
          chk("is_bullet", 32'(is_bullet), 32'(r[0]));
        end
      end
    end
  end

  always @(negedge Clk) if (fire === 1'b1) fire_seen <= fire_seen + 1;

  // scenario
  initial begin
    logic       pc, et, eb, ef;
    logic [9:0] dx, dy;
    logic [7:0] key;
    logic [3:0] em;

    Reset = 1'b1; frame_clk = 1'b0; keycode = K_NONE; DrawX = '0; DrawY = '0;
    repeat (3) @(negedge Clk);
    chk("rst_X", 32'(tank_X), 32'd500);
    chk("rst_Y", 32'(tank_Y), 32'd240);
    chk("rst_dir", 32'(tank_dir), 32'd1);
    chk("rst_mask", 32'(bullets_active), 32'd0);
    chk("rst_fire", 32'(fire), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // turn to face right, ending back at the start position
    step(K_A, 10'd499, 10'd240, 3'd3, 4'd0, 1'b0);
    frame(K_D, 10'd500, 10'd240, 3'd2, 4'd0, 1'b0, 1'b1, 10'd500, 10'd240, 1'b1, 1'b0);

    // single shot right: spawn (532,252), last position 632, retires on 27th tick
    frame(K_EN, 10'd500, 10'd240, 3'd2, 4'd1, 1'b1, 1'b1, 10'd532, 10'd252, 1'b0, 1'b1);
    for (int t = 2; t <= 27; t++) begin
      pc = 1'b1; et = 1'b0; eb = 1'b0; dx = 10'd639; dy = 10'd259;
      case (t)
        2:  begin dx = 10'd531; dy = 10'd271; et = 1'b1; end
        3:  begin dx = 10'd532; dy = 10'd240; end
        4:  begin dx = 10'd500; dy = 10'd272; end
        26: eb = 1'b1;
        27: ;
        default: pc = 1'b0;
      endcase
      frame(K_NONE, 10'd500, 10'd240, 3'd2, 4'(t <= 26), 1'b0, pc, dx, dy, et, eb);
    end

    // Enter held 40 ticks fires once
    for (int h = 1; h <= 40; h++)
      step(K_EN, 10'd500, 10'd240, 3'd2, 4'(h <= 26), h == 1);

    // cooldown: requests every other tick are refused until 16 ticks after a shot
    step(K_NONE, 10'd500, 10'd240, 3'd2, 4'd0, 1'b0);
    for (int j = 0; j <= 46; j++) begin
      key = (j <= 16 && (j % 2) == 0) ? K_EN : K_NONE;
      em  = {2'b00, (j >= 16 && j < 42), (j < 26)};
      step(key, 10'd500, 10'd240, 3'd2, em, (j == 0) || (j == 16));
    end

    // drive to Y=4 facing up, fire: spawn clamps to y=0 and retires next tick
    for (int k = 1; k <= 236; k++)
      step(K_W, 10'd500, 10'(240 - k), 3'd1, 4'd0, 1'b0);
    frame(K_EN, 10'd500, 10'd4, 3'd1, 4'd1, 1'b1, 1'b1, 10'd512, 10'd0, 1'b0, 1'b1);
    step(K_NONE, 10'd500, 10'd4, 3'd1, 4'd0, 1'b0);
    for (int k = 1; k <= 20; k++)
      step(K_W, 10'd500, (k >= 4) ? 10'd0 : 10'(4 - k), 3'd1, 4'd0, 1'b0);

    // face down and fill the pool; full-pool and retire-same-tick requests are refused
    step(K_S, 10'd500, 10'd1, 3'd4, 4'd0, 1'b0);
    for (int r = 0; r <= 113; r++) begin
      key = (r == 0 || r == 16 || r == 32 || r == 48 || r == 64 || r == 110 || r == 112)
            ? K_EN : K_NONE;
      em  = {(r >= 48), (r >= 32), (r >= 16), (r < 110 || r >= 112)};
      ef  = (r == 0 || r == 16 || r == 32 || r == 48 || r == 112);
      pc = 1'b1; et = 1'b0; eb = 1'b0; dx = 10'd512; dy = 10'd33;
      case (r)
        1:   begin dx = 10'd531; dy = 10'd32; et = 1'b1; end
        111: ;
        112: eb = 1'b1;
        default: pc = 1'b0;
      endcase
      frame(key, 10'd500, 10'd1, 3'd4, em, ef, pc, dx, dy, et, eb);
    end

    // asynchronous reset with a full pool clears everything immediately
    #2 Reset = 1'b1;
    #1;
    chk("midrst_mask", 32'(bullets_active), 32'd0);
    chk("midrst_X", 32'(tank_X), 32'd500);
    chk("midrst_Y", 32'(tank_Y), 32'd240);
    chk("midrst_dir", 32'(tank_dir), 32'd1);
    chk("midrst_fire", 32'(fire), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    step(K_NONE, 10'd500, 10'd240, 3'd1, 4'd0, 1'b0);

    // hold D: X saturates at 608
    for (int k = 1; k <= 200; k++)
      step(K_D, (k >= 108) ? 10'd608 : 10'(500 + k), 10'd240, 3'd2, 4'd0, 1'b0);

    repeat (4) @(negedge Clk);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    chk("fire_count", 32'(fire_seen), 32'(exp_fires));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
